instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the processor core (main). It holds the fetch PC and issues word reads to a synchronous instruction ROM with 1-cycle read latency. It delivers {pc, instruction} pairs to the core over a valid/ready handshake. A 2-entry output buffer absorbs core back-pressure, and a redirect input flushes the stage for branches and jumps.

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Purpose : fetch PC + synchronous ROM reader; hands {pc, instr} pairs to the core.
// Latency : issue the cycle after reset release, first out_valid 2 cycles after issue.
// Backpr. : 2-entry output buffer; issue stalls when buffer + in-flight read would exceed 2.
//
// Ports: clk/rst (sync, active high); halt stops issue; redirect_valid/redirect_pc
// flush and refetch; imem_en/imem_addr/imem_rdata drive a 1-cycle-latency ROM;
// out_valid/out_ready/out_instr/out_pc carry the buffer head; cur_pc is the fetch PC.
// Optional feature macro: FETCH_MISALIGN_CHK_EN adds the misalign output, which
// latches on a redirect to a non-word-aligned target and blocks issue until reset.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [31:0]       cur_pc
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic              misalign
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] tag_q, tag_d;          // PC of the read currently in flight
    logic        inflight_q, inflight_d;
    logic        kill_q, kill_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] hd_pc_q, hd_pc_d, hd_ins_q, hd_ins_d;   // buffer head
    logic [31:0] tl_pc_q, tl_pc_d, tl_ins_q, tl_ins_d;   // buffer second entry
    logic        hold_q, hold_d;        // sticky issue block (misalign trap)

    logic        pop, push, room;
    logic [31:0] redir_tgt;

`ifdef FETCH_MISALIGN_CHK_EN
    assign redir_tgt = redirect_pc;
    assign misalign  = hold_q;
`else
    logic unused_redirect_lsb;
    assign redir_tgt           = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    assign out_valid = (count_q != 2'd0);
    assign out_pc    = hd_pc_q;
    assign out_instr = hd_ins_q;
    assign cur_pc    = pc_q;
    assign imem_addr = pc_q[ADDR_W+1:2];

    assign pop  = out_valid && out_ready;
    assign push = inflight_q && !kill_q;
    // count + inflight < 2
    assign room = (count_q == 2'd0) || ((count_q == 2'd1) && !inflight_q);
    // A pop frees a slot this edge, so issue may proceed into a "full" state.
    assign imem_en = !rst && !halt && !hold_q && !redirect_valid && (room || pop);

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        kill_d     = 1'b0;
        count_d    = count_q;
        hd_pc_d    = hd_pc_q;
        hd_ins_d   = hd_ins_q;
        tl_pc_d    = tl_pc_q;
        tl_ins_d   = tl_ins_q;
        hold_d     = hold_q;

        if (redirect_valid) begin
            // Flush: buffered entries and the response arriving now are discarded.
            pc_d    = redir_tgt;
            count_d = 2'd0;
            kill_d  = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                hold_d = 1'b1;
            end
`endif
        end else begin
            inflight_d = imem_en;
            if (imem_en) begin
                tag_d = pc_q;
                pc_d  = pc_q + 32'd4;
            end

            case ({pop, push})
                2'b10: begin
                    hd_pc_d  = tl_pc_q;
                    hd_ins_d = tl_ins_q;
                    count_d  = count_q - 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd0) begin
                        hd_pc_d  = tag_q;
                        hd_ins_d = imem_rdata;
                    end else begin
                        tl_pc_d  = tag_q;
                        tl_ins_d = imem_rdata;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new entry lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        hd_pc_d  = tag_q;
                        hd_ins_d = imem_rdata;
                    end else begin
                        hd_pc_d  = tl_pc_q;
                        hd_ins_d = tl_ins_q;
                        tl_pc_d  = tag_q;
                        tl_ins_d = imem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= 32'd0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            count_q    <= 2'd0;
            hd_pc_q    <= 32'd0;
            hd_ins_q   <= 32'd0;
            tl_pc_q    <= 32'd0;
            tl_ins_q   <= 32'd0;
            hold_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            count_q    <= count_d;
            hd_pc_q    <= hd_pc_d;
            hd_ins_q   <= hd_ins_d;
            tl_pc_q    <= tl_pc_d;
            tl_ins_q   <= tl_ins_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose : directed bench for instr_fetch_unit (streaming, back-pressure, redirect, halt, reset, PC wrap).
// Latency : inputs driven 1 time unit after posedge, outputs sampled 1 unit after negedge.
// Backpr. : out_ready driven by the stimulus; a second instance always accepts.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, halt, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr, out_pc, cur_pc;

    // Second instance: reset near the top of the address space, never stalled.
    logic        w_halt = 1'b0, w_redirect_valid = 1'b0, w_out_ready = 1'b1;
    logic [31:0] w_redirect_pc = 32'd0;
    logic        w_imem_en;
    logic [7:0]  w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_out_valid;
    logic [31:0] w_out_instr, w_out_pc, w_cur_pc;

`ifdef FETCH_MISALIGN_CHK_EN
    logic        mis_a, mis_b;
`endif

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .cur_pc(cur_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        , .misalign(mis_a)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .ADDR_W(8)) dut_w (
        .clk(clk), .rst(rst), .halt(w_halt),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .cur_pc(w_cur_pc)
`ifdef FETCH_MISALIGN_CHK_EN
        , .misalign(mis_b)
`endif
    );

    // ROM: word n holds A000_0000 + n, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= 32'hA000_0000 + {24'h0, imem_addr};
        if (w_imem_en) w_imem_rdata <= 32'hA000_0000 + {24'h0, w_imem_addr};
    end

    int errors = 0;
    int checks = 0;
    int viol   = 0;
    logic [31:0] q_pc[$], q_ins[$], wq_pc[$], wq_ins[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    // Record completed transfers and watch buffer occupancy.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q_pc.push_back(out_pc);
            q_ins.push_back(out_instr);
        end
        if (rst) begin
            wq_pc.delete();
            wq_ins.delete();
        end else if (w_out_valid && w_out_ready) begin
            wq_pc.push_back(w_out_pc);
            wq_ins.push_back(w_out_instr);
        end
        if (!rst && (({1'b0, dut.count_q} + {2'b00, dut.inflight_q}) > 3'd2)) viol++;
    end

    logic [31:0] exp_pc[6], exp_ins[6];

    initial begin
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
        step(); step();
        smp();
        check("rst_en",     {31'd0, imem_en},   32'd0);
        check("rst_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_instr",  out_instr,          32'd0);
        check("rst_pc",     out_pc,             32'd0);
        check("rst_cur_pc", cur_pc,             32'd0);
        check("rst_w_cur",  w_cur_pc,           32'hFFFF_FFF8);

        // C1: reset released, streaming with out_ready high
        step(); rst = 1'b0; q_pc.delete(); q_ins.delete();
        smp();
        check("c1_en",    {31'd0, imem_en},   32'd1);
        check("c1_addr",  {24'd0, imem_addr}, 32'd0);
        check("c1_valid", {31'd0, out_valid}, 32'd0);
        check("w_c1_addr", {24'd0, w_imem_addr}, 32'h0000_00FE);
        step(); smp();                               // C2
        check("c2_addr",  {24'd0, imem_addr}, 32'd1);
        check("c2_valid", {31'd0, out_valid}, 32'd0);
        step(); smp();                               // C3
        check("c3_valid", {31'd0, out_valid}, 32'd1);
        check("c3_pc",    out_pc,             32'h0);
        check("c3_instr", out_instr,          32'hA000_0000);
        step(); step();                              // C4, C5
        step(); redirect_valid = 1'b1; redirect_pc = 32'h40;   // C6
        smp();
        check("redir_en", {31'd0, imem_en}, 32'd0);
        step(); redirect_valid = 1'b0;               // C7
        smp();
        check("c7_en",    {31'd0, imem_en},   32'd1);
        check("c7_addr",  {24'd0, imem_addr}, 32'h10);
        check("c7_valid", {31'd0, out_valid}, 32'd0);
        step(); smp();                               // C8
        check("c8_valid", {31'd0, out_valid}, 32'd0);
        step(); smp();                               // C9
        check("c9_valid", {31'd0, out_valid}, 32'd1);
        check("c9_pc",    out_pc,             32'h40);
        check("c9_instr", out_instr,          32'hA000_0010);
        step(); smp();                               // C10
        exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h44};
        exp_ins = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                    32'hA000_0010, 32'hA000_0011};
        check("stream_len", q_pc.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("stream_pc%0d", i),  (i < q_pc.size())  ? q_pc[i]  : 32'hDEAD_DEAD, exp_pc[i]);
            check($sformatf("stream_ins%0d", i), (i < q_ins.size()) ? q_ins[i] : 32'hDEAD_DEAD, exp_ins[i]);
        end

        // C11..C15: halt, buffer drains, PC frozen
        step(); halt = 1'b1; q_pc.delete(); q_ins.delete();
        smp();
        check("halt_en",  {31'd0, imem_en}, 32'd0);
        check("halt_cur", cur_pc,           32'h50);
        step(); step(); smp();                       // C13
        check("halt_drained", {31'd0, out_valid}, 32'd0);
        step(); step(); smp();                       // C15
        check("halt_valid15", {31'd0, out_valid}, 32'd0);
        check("halt_cur15",   cur_pc,             32'h50);
        step(); halt = 1'b0;                         // C16
        smp();
        check("resume_en",   {31'd0, imem_en},   32'd1);
        check("resume_addr", {24'd0, imem_addr}, 32'h14);
        step(); step(); smp();                       // C18
        check("resume_pc",    out_pc,    32'h50);
        check("resume_instr", out_instr, 32'hA000_0014);
        check("halt_q_len",   q_pc.size(), 32'd3);
        check("halt_q0", (q_pc.size() > 0) ? q_pc[0] : 32'hDEAD_DEAD, 32'h48);
        check("halt_q1", (q_pc.size() > 1) ? q_pc[1] : 32'hDEAD_DEAD, 32'h4C);
        check("halt_q2", (q_pc.size() > 2) ? q_pc[2] : 32'hDEAD_DEAD, 32'h50);

        // C19: one-cycle reset with an entry buffered and a read in flight
        step(); out_ready = 1'b0; rst = 1'b1;
        smp();
        check("rst2_en", {31'd0, imem_en}, 32'd0);
        step(); rst = 1'b0; q_pc.delete(); q_ins.delete();   // C20
        smp();
        check("rst2_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_pc",    out_pc,             32'd0);
        check("rst2_instr", out_instr,          32'd0);
        check("rst2_cur",   cur_pc,             32'd0);
        check("rst2_en1",   {31'd0, imem_en},   32'd1);
        step(); smp();                               // C21
        check("bp_addr1", {24'd0, imem_addr}, 32'd1);
        step(); smp();                               // C22
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_en22",  {31'd0, imem_en},   32'd0);
        repeat (5) step();
        smp();                                       // C27
        check("bp_en27",   {31'd0, imem_en},   32'd0);
        check("bp_valid27", {31'd0, out_valid}, 32'd1);
        check("bp_head_pc", out_pc,            32'h0);
        check("bp_head_in", out_instr,         32'hA000_0000);
        step(); out_ready = 1'b1;                    // C28
        smp();
        check("bp_resume_en",   {31'd0, imem_en},   32'd1);
        check("bp_resume_addr", {24'd0, imem_addr}, 32'd2);
        repeat (5) step();
        smp();                                       // C33
        check("bp_len", q_pc.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_pc%0d", i),  (i < q_pc.size())  ? q_pc[i]  : 32'hDEAD_DEAD, 32'(4 * i));
            check($sformatf("bp_ins%0d", i), (i < q_ins.size()) ? q_ins[i] : 32'hDEAD_DEAD,
                  32'hA000_0000 + 32'(i));
        end

        // Wrap-around instance, streaming since the C19 reset
        check("wrap_pc0",  (wq_pc.size()  > 0) ? wq_pc[0]  : 32'hDEAD_DEAD, 32'hFFFF_FFF8);
        check("wrap_ins0", (wq_ins.size() > 0) ? wq_ins[0] : 32'hDEAD_DEAD, 32'hA000_00FE);
        check("wrap_pc1",  (wq_pc.size()  > 1) ? wq_pc[1]  : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
        check("wrap_ins1", (wq_ins.size() > 1) ? wq_ins[1] : 32'hDEAD_DEAD, 32'hA000_00FF);
        check("wrap_pc2",  (wq_pc.size()  > 2) ? wq_pc[2]  : 32'hDEAD_DEAD, 32'h0000_0000);
        check("wrap_ins2", (wq_ins.size() > 2) ? wq_ins[2] : 32'hDEAD_DEAD, 32'hA000_0000);

        check("occupancy_violations", viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
